// File: rtl/pipe_tracker_pkg.sv
// Shared definitions for the pipeline tracker: stall watchdog limit, stall FSM
// encoding and the ID/EX bubble image also used by hazard-unit side code.
package pipe_tracker_pkg;

   localparam int STALL_LIMIT = 15;
   localparam int RUN_CNT_W   = 4;
   localparam int STALL_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_STALL   = 2'b01,
      ST_TIMEOUT = 2'b10
   } stall_state_e;

   typedef struct packed {
      logic       a_s;
      logic       b_s;
      logic       d_s;
      logic       sr;
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rd;
      logic       rf_le;
      logic       l;
      logic       cc_we;
      logic       nop;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '{
      a_s: 1'b0, b_s: 1'b0, d_s: 1'b0, sr: 1'b0,
      ra: 5'd0, rb: 5'd0, rd: 5'd0,
      rf_le: 1'b0, l: 1'b0, cc_we: 1'b0, nop: 1'b1
   };

   // r0 is hardwired, so a write to it must never look like a forwarding source.
   function automatic logic rf_le_gate(input logic le, input logic [4:0] rd);
      return le & (rd != 5'd0);
   endfunction

endpackage

// File: rtl/pipe_tracker_stall_monitor.sv
// Stall watchdog: RUN/STALL/TIMEOUT FSM with a consecutive-stall run counter
// and a saturating total stall-cycle counter.
module stall_monitor
   import pipe_tracker_pkg::*;
#(
   parameter int LIMIT = STALL_LIMIT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_stall,
   output logic [STALL_CNT_W-1:0] o_stall_cnt,
   output logic                   o_stall_timeout
);

   localparam logic [RUN_CNT_W-1:0] LIMIT_M1 = RUN_CNT_W'(LIMIT - 1);

   stall_state_e          r_state;
   stall_state_e          w_state_next;
   logic [RUN_CNT_W-1:0]  r_run_cnt;
   logic [RUN_CNT_W-1:0]  w_run_cnt_next;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_run_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_run_cnt <= w_run_cnt_next;
      end
   end

   // Timeout fires on the stalled cycle that brings the run counter up to LIMIT.
   always_comb begin
      w_state_next   = r_state;
      w_run_cnt_next = r_run_cnt;
      case (r_state)
         ST_RUN: begin
            w_run_cnt_next = '0;
            if (i_stall) w_state_next = ST_STALL;
         end
         ST_STALL: begin
            if (!i_stall) begin
               w_state_next   = ST_RUN;
               w_run_cnt_next = '0;
            end else begin
               w_run_cnt_next = r_run_cnt + 1'b1;
               if (r_run_cnt == LIMIT_M1) w_state_next = ST_TIMEOUT;
            end
         end
         ST_TIMEOUT: begin
            w_state_next   = ST_TIMEOUT;
            w_run_cnt_next = r_run_cnt;
         end
         default: begin
            w_state_next   = ST_RUN;
            w_run_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (i_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_stall_cnt     = r_stall_cnt;
   assign o_stall_timeout = (r_state == ST_TIMEOUT);

endmodule

// File: rtl/pipe_tracker.sv
// ID/EX/MEM/WB control-field tracker feeding the hazard unit, plus the stall
// watchdog statistics.
module pipe_tracker
   import pipe_tracker_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        A_S_ID,
   input  logic        B_S_ID,
   input  logic        D_S_ID,
   input  logic        SR_ID,
   input  logic [4:0]  RA_ID,
   input  logic [4:0]  RB_ID,
   input  logic [4:0]  RD_ID,
   input  logic        RF_LE_ID,
   input  logic        L_ID,
   input  logic        CC_WE_ID,
   input  logic        VALID_ID,
   input  logic        stall_D,
   input  logic        flush_E,
   input  logic        annul_D,
   output logic        A_S_EX,
   output logic        B_S_EX,
   output logic        D_S_EX,
   output logic        SR_EX,
   output logic [4:0]  RA_EX,
   output logic [4:0]  RB_EX,
   output logic [4:0]  RD_EX,
   output logic        RF_LE_EX,
   output logic        L_EX,
   output logic        CC_WE_EX,
   output logic        ID_NOP_EX,
   output logic [4:0]  RD_MEM,
   output logic [4:0]  RD_WB,
   output logic        RF_LE_MEM,
   output logic        RF_LE_WB,
   output logic [15:0] stall_cnt,
   output logic        stall_timeout
);

   idex_t      r_idex;
   idex_t      w_idex_next;
   logic [4:0] r_rd_mem;
   logic [4:0] r_rd_wb;
   logic       r_rf_le_mem;
   logic       r_rf_le_wb;

   // stall_D is deliberately ignored here: the hazard unit pairs it with flush_E.
   always_comb begin
      w_idex_next = IDEX_BUBBLE;
      if (!flush_E && !annul_D && VALID_ID) begin
         w_idex_next.a_s   = A_S_ID;
         w_idex_next.b_s   = B_S_ID;
         w_idex_next.d_s   = D_S_ID;
         w_idex_next.sr    = SR_ID;
         w_idex_next.ra    = RA_ID;
         w_idex_next.rb    = RB_ID;
         w_idex_next.rd    = RD_ID;
         w_idex_next.rf_le = RF_LE_ID;
         w_idex_next.l     = L_ID;
         w_idex_next.cc_we = CC_WE_ID;
         w_idex_next.nop   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idex      <= IDEX_BUBBLE;
         r_rd_mem    <= 5'd0;
         r_rd_wb     <= 5'd0;
         r_rf_le_mem <= 1'b0;
         r_rf_le_wb  <= 1'b0;
      end else begin
         r_idex      <= w_idex_next;
         r_rd_mem    <= r_idex.rd;
         r_rd_wb     <= r_rd_mem;
         r_rf_le_mem <= rf_le_gate(r_idex.rf_le & ~r_idex.nop, r_idex.rd);
         r_rf_le_wb  <= rf_le_gate(r_rf_le_mem, r_rd_mem);
      end
   end

   stall_monitor #(
      .LIMIT (STALL_LIMIT)
   ) u_stall_monitor (
      .clk             (clk),
      .rst             (rst),
      .i_stall         (stall_D),
      .o_stall_cnt     (stall_cnt),
      .o_stall_timeout (stall_timeout)
   );

   assign A_S_EX    = r_idex.a_s;
   assign B_S_EX    = r_idex.b_s;
   assign D_S_EX    = r_idex.d_s;
   assign SR_EX     = r_idex.sr;
   assign RA_EX     = r_idex.ra;
   assign RB_EX     = r_idex.rb;
   assign RD_EX     = r_idex.rd;
   assign RF_LE_EX  = r_idex.rf_le;
   assign L_EX      = r_idex.l;
   assign CC_WE_EX  = r_idex.cc_we;
   assign ID_NOP_EX = r_idex.nop;
   assign RD_MEM    = r_rd_mem;
   assign RD_WB     = r_rd_wb;
   assign RF_LE_MEM = r_rf_le_mem;
   assign RF_LE_WB  = r_rf_le_wb;

endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker: stage propagation, bubbles, r0 gating,
// stall watchdog, counter saturation and asynchronous reset.
module tb_pipe_tracker;

   logic        clk = 1'b0;
   logic        rst;
   logic        A_S_ID, B_S_ID, D_S_ID, SR_ID;
   logic [4:0]  RA_ID, RB_ID, RD_ID;
   logic        RF_LE_ID, L_ID, CC_WE_ID, VALID_ID;
   logic        stall_D, flush_E, annul_D;
   logic        A_S_EX, B_S_EX, D_S_EX, SR_EX;
   logic [4:0]  RA_EX, RB_EX, RD_EX;
   logic        RF_LE_EX, L_EX, CC_WE_EX, ID_NOP_EX;
   logic [4:0]  RD_MEM, RD_WB;
   logic        RF_LE_MEM, RF_LE_WB;
   logic [15:0] stall_cnt;
   logic        stall_timeout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_tracker dut (
      .clk(clk), .rst(rst),
      .A_S_ID(A_S_ID), .B_S_ID(B_S_ID), .D_S_ID(D_S_ID), .SR_ID(SR_ID),
      .RA_ID(RA_ID), .RB_ID(RB_ID), .RD_ID(RD_ID),
      .RF_LE_ID(RF_LE_ID), .L_ID(L_ID), .CC_WE_ID(CC_WE_ID), .VALID_ID(VALID_ID),
      .stall_D(stall_D), .flush_E(flush_E), .annul_D(annul_D),
      .A_S_EX(A_S_EX), .B_S_EX(B_S_EX), .D_S_EX(D_S_EX), .SR_EX(SR_EX),
      .RA_EX(RA_EX), .RB_EX(RB_EX), .RD_EX(RD_EX),
      .RF_LE_EX(RF_LE_EX), .L_EX(L_EX), .CC_WE_EX(CC_WE_EX), .ID_NOP_EX(ID_NOP_EX),
      .RD_MEM(RD_MEM), .RD_WB(RD_WB), .RF_LE_MEM(RF_LE_MEM), .RF_LE_WB(RF_LE_WB),
      .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
   );

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      {A_S_ID, B_S_ID, D_S_ID, SR_ID} = 4'b0000;
      RA_ID = 5'd0; RB_ID = 5'd0; RD_ID = 5'd0;
      {RF_LE_ID, L_ID, CC_WE_ID, VALID_ID} = 4'b0000;
      {stall_D, flush_E, annul_D} = 3'b000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RD_ID = 5'd9; RF_LE_ID = 1'b1; VALID_ID = 1'b1; stall_D = 1'b1;
      rst = 1'b1;
      tick(); tick();
      n_vec++; if (ID_NOP_EX !== 1'b1) begin n_err++; $display("FAIL rst_nop: got %0b want 1", ID_NOP_EX); end
      n_vec++; if ({A_S_EX, B_S_EX, D_S_EX, SR_EX, RA_EX, RB_EX, RD_EX, RF_LE_EX, L_EX, CC_WE_EX} !== 25'd0) begin n_err++; $display("FAIL rst_ex: got nonzero EX fields want 0"); end
      n_vec++; if ({RD_MEM, RD_WB, RF_LE_MEM, RF_LE_WB} !== 12'd0) begin n_err++; $display("FAIL rst_mem_wb: got %h want 0", {RD_MEM, RD_WB, RF_LE_MEM, RF_LE_WB}); end
      n_vec++; if (stall_cnt !== 16'd0 || stall_timeout !== 1'b0) begin n_err++; $display("FAIL rst_stats: got cnt=%0d to=%0b want 0/0", stall_cnt, stall_timeout); end
      rst = 1'b0;
      idle_inputs();
      $display("-- test_reset done");
   endtask

   task automatic test_propagate();
      idle_inputs();
      A_S_ID = 1'b1; SR_ID = 1'b1; L_ID = 1'b1; CC_WE_ID = 1'b1;
      RA_ID = 5'd3; RB_ID = 5'd4; RD_ID = 5'd5; RF_LE_ID = 1'b1; VALID_ID = 1'b1;
      tick();
      idle_inputs();
      n_vec++; if (RD_EX !== 5'd5 || ID_NOP_EX !== 1'b0 || RF_LE_EX !== 1'b1) begin n_err++; $display("FAIL prop_ex: got rd=%0d nop=%0b le=%0b want 5/0/1", RD_EX, ID_NOP_EX, RF_LE_EX); end
      n_vec++; if (RA_EX !== 5'd3 || RB_EX !== 5'd4 || {A_S_EX, B_S_EX, D_S_EX, SR_EX, L_EX, CC_WE_EX} !== 6'b100111) begin n_err++; $display("FAIL prop_ex_fields: got ra=%0d rb=%0d flags=%b want 3/4/100111", RA_EX, RB_EX, {A_S_EX, B_S_EX, D_S_EX, SR_EX, L_EX, CC_WE_EX}); end
      tick();
      n_vec++; if (RD_MEM !== 5'd5 || RF_LE_MEM !== 1'b1) begin n_err++; $display("FAIL prop_mem: got rd=%0d le=%0b want 5/1", RD_MEM, RF_LE_MEM); end
      n_vec++; if (ID_NOP_EX !== 1'b1 || RD_EX !== 5'd0) begin n_err++; $display("FAIL prop_invalid_bubble: got nop=%0b rd=%0d want 1/0", ID_NOP_EX, RD_EX); end
      tick();
      n_vec++; if (RD_WB !== 5'd5 || RF_LE_WB !== 1'b1 || RF_LE_MEM !== 1'b0) begin n_err++; $display("FAIL prop_wb: got rd=%0d le=%0b lemem=%0b want 5/1/0", RD_WB, RF_LE_WB, RF_LE_MEM); end
      $display("-- test_propagate done");
   endtask

   task automatic test_flush_annul();
      idle_inputs();
      RD_ID = 5'd7; RF_LE_ID = 1'b1; VALID_ID = 1'b1; RA_ID = 5'd2; L_ID = 1'b1;
      flush_E = 1'b1; annul_D = 1'b1;
      tick();
      idle_inputs();
      n_vec++; if (ID_NOP_EX !== 1'b1 || RD_EX !== 5'd0 || RA_EX !== 5'd0 || RF_LE_EX !== 1'b0 || L_EX !== 1'b0) begin n_err++; $display("FAIL flush_annul_ex: got nop=%0b rd=%0d ra=%0d le=%0b l=%0b want 1/0/0/0/0", ID_NOP_EX, RD_EX, RA_EX, RF_LE_EX, L_EX); end
      tick();
      n_vec++; if (RF_LE_MEM !== 1'b0 || RD_MEM !== 5'd0) begin n_err++; $display("FAIL flush_annul_mem: got le=%0b rd=%0d want 0/0", RF_LE_MEM, RD_MEM); end
      // flush alone also bubbles a valid instruction
      RD_ID = 5'd12; RF_LE_ID = 1'b1; VALID_ID = 1'b1; flush_E = 1'b1;
      tick();
      idle_inputs();
      n_vec++; if (ID_NOP_EX !== 1'b1 || RD_EX !== 5'd0) begin n_err++; $display("FAIL flush_only: got nop=%0b rd=%0d want 1/0", ID_NOP_EX, RD_EX); end
      $display("-- test_flush_annul done");
   endtask

   task automatic test_r0();
      idle_inputs();
      RD_ID = 5'd0; RF_LE_ID = 1'b1; VALID_ID = 1'b1;
      tick();
      idle_inputs();
      n_vec++; if (RF_LE_EX !== 1'b1 || ID_NOP_EX !== 1'b0) begin n_err++; $display("FAIL r0_ex: got le=%0b nop=%0b want 1/0", RF_LE_EX, ID_NOP_EX); end
      tick();
      n_vec++; if (RF_LE_MEM !== 1'b0) begin n_err++; $display("FAIL r0_mem: got le=%0b want 0", RF_LE_MEM); end
      tick();
      n_vec++; if (RF_LE_WB !== 1'b0) begin n_err++; $display("FAIL r0_wb: got le=%0b want 0", RF_LE_WB); end
      $display("-- test_r0 done");
   endtask

   task automatic test_stall_annul();
      idle_inputs();
      RD_ID = 5'd9; RF_LE_ID = 1'b1; VALID_ID = 1'b1; stall_D = 1'b1; annul_D = 1'b1;
      tick();
      n_vec++; if (ID_NOP_EX !== 1'b1 || RD_EX !== 5'd0) begin n_err++; $display("FAIL stall_annul_ex: got nop=%0b rd=%0d want 1/0", ID_NOP_EX, RD_EX); end
      n_vec++; if (stall_cnt !== 16'd1 || stall_timeout !== 1'b0) begin n_err++; $display("FAIL stall_annul_cnt: got cnt=%0d to=%0b want 1/0", stall_cnt, stall_timeout); end
      // stall alone leaves ID/EX loading untouched
      annul_D = 1'b0; RD_ID = 5'd6;
      tick();
      idle_inputs();
      n_vec++; if (ID_NOP_EX !== 1'b0 || RD_EX !== 5'd6 || stall_cnt !== 16'd2) begin n_err++; $display("FAIL stall_only: got nop=%0b rd=%0d cnt=%0d want 0/6/2", ID_NOP_EX, RD_EX, stall_cnt); end
      tick();
      n_vec++; if (stall_cnt !== 16'd2 || RD_MEM !== 5'd6 || RF_LE_MEM !== 1'b1) begin n_err++; $display("FAIL stall_release: got cnt=%0d rdmem=%0d le=%0b want 2/6/1", stall_cnt, RD_MEM, RF_LE_MEM); end
      $display("-- test_stall_annul done");
   endtask

   task automatic test_timeout();
      idle_inputs();
      do_reset();
      stall_D = 1'b1;
      repeat (15) tick();
      n_vec++; if (stall_timeout !== 1'b0 || stall_cnt !== 16'd15) begin n_err++; $display("FAIL timeout_early: got to=%0b cnt=%0d want 0/15", stall_timeout, stall_cnt); end
      tick();
      n_vec++; if (stall_timeout !== 1'b1 || stall_cnt !== 16'd16) begin n_err++; $display("FAIL timeout_16: got to=%0b cnt=%0d want 1/16", stall_timeout, stall_cnt); end
      stall_D = 1'b0;
      RD_ID = 5'd11; RF_LE_ID = 1'b1; VALID_ID = 1'b1;
      tick();
      idle_inputs();
      tick();
      n_vec++; if (stall_timeout !== 1'b1 || stall_cnt !== 16'd16) begin n_err++; $display("FAIL timeout_sticky: got to=%0b cnt=%0d want 1/16", stall_timeout, stall_cnt); end
      n_vec++; if (RD_MEM !== 5'd11 || RF_LE_MEM !== 1'b1) begin n_err++; $display("FAIL timeout_pipe: got rd=%0d le=%0b want 11/1", RD_MEM, RF_LE_MEM); end
      $display("-- test_timeout done");
   endtask

   task automatic test_async_reset();
      idle_inputs();
      stall_D = 1'b1;
      RD_ID = 5'd13; RF_LE_ID = 1'b1; VALID_ID = 1'b1;
      tick(); tick();
      // state now: timeout sticky, stage registers loaded with rd 13
      #3 rst = 1'b1;
      #1;
      n_vec++; if (stall_timeout !== 1'b0 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL async_rst_stats: got to=%0b cnt=%0d want 0/0", stall_timeout, stall_cnt); end
      n_vec++; if (ID_NOP_EX !== 1'b1 || RD_EX !== 5'd0 || RD_MEM !== 5'd0 || RD_WB !== 5'd0 || RF_LE_MEM !== 1'b0 || RF_LE_EX !== 1'b0) begin n_err++; $display("FAIL async_rst_pipe: got nop=%0b rd=%0d/%0d/%0d want 1/0/0/0", ID_NOP_EX, RD_EX, RD_MEM, RD_WB); end
      #2 rst = 1'b0;
      stall_D = 1'b0;
      RD_ID = 5'd14;
      tick();
      idle_inputs();
      n_vec++; if (ID_NOP_EX !== 1'b0 || RD_EX !== 5'd14 || stall_cnt !== 16'd0 || stall_timeout !== 1'b0) begin n_err++; $display("FAIL post_rst_first: got nop=%0b rd=%0d cnt=%0d to=%0b want 0/14/0/0", ID_NOP_EX, RD_EX, stall_cnt, stall_timeout); end
      $display("-- test_async_reset done");
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      VALID_ID = 1'b1; RF_LE_ID = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         RD_ID = 5'(i + 20);
         tick();
      end
      idle_inputs();
      n_vec++; if (RD_EX !== 5'd23 || RD_MEM !== 5'd22 || RD_WB !== 5'd21) begin n_err++; $display("FAIL b2b_rd: got %0d/%0d/%0d want 23/22/21", RD_EX, RD_MEM, RD_WB); end
      n_vec++; if (RF_LE_MEM !== 1'b1 || RF_LE_WB !== 1'b1) begin n_err++; $display("FAIL b2b_le: got %0b/%0b want 1/1", RF_LE_MEM, RF_LE_WB); end
      $display("-- test_back_to_back done");
   endtask

   task automatic test_saturate();
      idle_inputs();
      do_reset();
      stall_D = 1'b1;
      repeat (65533) tick();
      n_vec++; if (stall_cnt !== 16'hFFFD) begin n_err++; $display("FAIL sat_pre: got %h want fffd", stall_cnt); end
      tick();
      n_vec++; if (stall_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold%0d: got %h want ffff", i, stall_cnt); end
      end
      idle_inputs();
      $display("-- test_saturate done");
   endtask

   initial begin
      test_reset();
      test_propagate();
      test_flush_annul();
      test_r0();
      test_stall_annul();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
